// File: rtl/mux_pkg.sv
// Shared types and the round-robin pick function for the 4:1 mux arbiter.
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam int NUM_CH = 4;

  typedef struct packed {
    logic found;
    sel_t sel;
  } pick_t;

  // Search last, last+1, last+2, last+3; last is skipped unless allow_last.
  // If last was skipped and nothing else is valid, last is granted anyway.
  function automatic pick_t rr_pick(input logic [NUM_CH-1:0] req,
                                    input sel_t              last,
                                    input logic              allow_last);
    pick_t p;
    sel_t  idx;
    p.found = 1'b0;
    p.sel   = last;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = sel_t'(32'(last) + k);
      if (!p.found && req[idx] && (k != 0 || allow_last)) begin
        p.found = 1'b1;
        p.sel   = idx;
      end
    end
    if (!p.found && req[last]) begin
      p.found = 1'b1;
      p.sel   = last;
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational rotate-and-find-first grant selection.
module rr_pick_comb
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              last,
  input  logic              allow_last,
  output logic              found,
  output sel_t              grant
);

  pick_t pick;

  always_comb begin
    pick  = rr_pick(req, last, allow_last);
    found = pick.found;
    grant = pick.sel;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select, with a registered one-entry output stage.
module rr_mux_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]       req_ready,
  output sel_t                    select,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready
);

  localparam int CNT_W = 4;

  sel_t             last_grant;
  logic [CNT_W-1:0] burst_cnt;
  logic             can_load;
  logic             allow_last;
  logic             found;
  sel_t             grant;
  logic             load;

  // burst_cnt is 0 only out of reset, so the reset value of last_grant is
  // not treated as a live burst and channel 0 gets first priority.
  assign allow_last = (burst_cnt != '0) && (burst_cnt < CNT_W'(MAX_BURST));
  assign can_load   = !out_valid || out_ready;
  assign load       = can_load && found && !reset;

  rr_pick_comb u_pick (
    .req        (req_valid),
    .last       (last_grant),
    .allow_last (allow_last),
    .found      (found),
    .grant      (grant)
  );

  always_comb begin
    req_ready = '0;
    if (load) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      select     <= '0;
      last_grant <= 2'd3;
      burst_cnt  <= '0;
    end else begin
      if (load) begin
        out_valid  <= 1'b1;
        out_data   <= req_data[grant*WIDTH +: WIDTH];
        select     <= grant;
        last_grant <= grant;
        if (grant == last_grant) begin
          if (burst_cnt < CNT_W'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;
        end else begin
          burst_cnt <= CNT_W'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: one instance per MAX_BURST setting.
module tb_rr_mux_arbiter;

  localparam int WIDTH = 4;

  logic                 clk;
  logic                 reset;
  logic [4*WIDTH-1:0]   req_data;
  logic [3:0]           rv   [2];
  logic                 ordy [2];
  logic [3:0]           rr   [2];
  logic [1:0]           sel  [2];
  logic                 ov   [2];
  logic [WIDTH-1:0]     od   [2];

  int unsigned checks_total;
  int unsigned checks_passed;
  int unsigned exp_q[$];

  rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_data(req_data),
    .req_ready(rr[0]), .select(sel[0]), .out_valid(ov[0]), .out_data(od[0]),
    .out_ready(ordy[0])
  );

  rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(2)) dut_b2 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_data(req_data),
    .req_ready(rr[1]), .select(sel[1]), .out_valid(ov[1]), .out_data(od[1]),
    .out_ready(ordy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] word(input int unsigned ch);
    return WIDTH'(4'b1100 + ch);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Entered and left at a negedge: drive, check handshake, let one posedge pass.
  task automatic cycle(input int unsigned inst, input logic [3:0] v, input logic r,
                       input logic [3:0] exp_rdy);
    int unsigned ch;
    rv[inst]   = v;
    ordy[inst] = r;
    #1;
    check_eq("req_ready", 32'(rr[inst]), 32'(exp_rdy));
    if (ov[inst]) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(ov[inst]), 32'd0);
      end else begin
        ch = r ? exp_q.pop_front() : exp_q[0];
        check_eq(r ? "drain_data" : "hold_data", 32'(od[inst]), 32'(word(ch)));
        check_eq(r ? "drain_sel" : "hold_sel", 32'(sel[inst]), ch);
      end
    end
    for (int unsigned i = 0; i < 4; i++)
      if (exp_rdy[i]) exp_q.push_back(i);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int unsigned inst);
    cycle(inst, 4'b0000, 1'b1, 4'b0000);
    check_eq("drain_empty", 32'(ov[inst]), 32'd0);
    check_eq("sb_empty", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      rv[i]   = '0;
      ordy[i] = 1'b0;
    end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    req_data = {4'b1111, 4'b1110, 4'b1101, 4'b1100};
    rv[1] = '0; ordy[1] = 1'b0;
    rv[0] = 4'b1111; ordy[0] = 1'b1;
    reset = 1'b1;
    #3;
    check_eq("rst_valid", 32'(ov[0]), 32'd0);
    check_eq("rst_select", 32'(sel[0]), 32'd0);
    check_eq("rst_ready", 32'(rr[0]), 32'd0);
    check_eq("rst_data", 32'(od[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // First grant after reset, then round robin with MAX_BURST=1
    cycle(0, 4'b1111, 1'b1, 4'b0001);
    check_eq("lat_valid", 32'(ov[0]), 32'd1);
    check_eq("lat_data", 32'(od[0]), 32'(4'b1100));
    cycle(0, 4'b1111, 1'b1, 4'b0010);
    cycle(0, 4'b1111, 1'b1, 4'b0100);
    cycle(0, 4'b1111, 1'b1, 4'b1000);
    cycle(0, 4'b1111, 1'b1, 4'b0001);
    // Backpressure: held word is channel 0; resume with channel 1
    for (int i = 0; i < 3; i++) cycle(0, 4'b1111, 1'b0, 4'b0000);
    cycle(0, 4'b1111, 1'b1, 4'b0010);
    cycle(0, 4'b1111, 1'b1, 4'b0100);
    drain(0);

    // Sparse requests
    do_reset();
    cycle(0, 4'b0100, 1'b1, 4'b0100);
    cycle(0, 4'b0000, 1'b1, 4'b0000);
    check_eq("sparse_idle", 32'(ov[0]), 32'd0);
    cycle(0, 4'b1001, 1'b1, 4'b1000);
    check_eq("sparse_data", 32'(od[0]), 32'(4'b1111));
    drain(0);

    // Burst limit with MAX_BURST=2
    do_reset();
    cycle(1, 4'b1111, 1'b1, 4'b0001);
    cycle(1, 4'b1111, 1'b1, 4'b0001);
    cycle(1, 4'b1111, 1'b1, 4'b0010);
    cycle(1, 4'b1111, 1'b1, 4'b0010);
    cycle(1, 4'b1111, 1'b1, 4'b0100);
    cycle(1, 4'b1111, 1'b1, 4'b0100);
    cycle(1, 4'b1111, 1'b1, 4'b1000);
    cycle(1, 4'b1111, 1'b1, 4'b1000);
    for (int i = 0; i < 4; i++) cycle(1, 4'b0001, 1'b1, 4'b0001);
    drain(1);

    // Asynchronous reset mid-stream
    do_reset();
    cycle(0, 4'b1111, 1'b1, 4'b0001);
    cycle(0, 4'b1111, 1'b1, 4'b0010);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_valid", 32'(ov[0]), 32'd0);
    check_eq("async_ready", 32'(rr[0]), 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle(0, 4'b1111, 1'b1, 4'b0001);
    check_eq("async_restart", 32'(od[0]), 32'(4'b1100));
    drain(0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
